// File: rtl/stim_pkg.sv
// Shared types for the stimulation sequencer: FSM state encoding, phase strobes
// and the raw phase ordering used before zero-length phases are skipped.
package stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAT,
    S_IPD,
    S_ANO,
    S_DIS,
    S_REST
  } state_t;

  typedef struct packed {
    logic cat;
    logic ano;
    logic dis;
  } strobe_t;

  function automatic state_t stim_next_raw(state_t s);
    state_t n;
    case (s)
      S_CAT:   n = S_IPD;
      S_IPD:   n = S_ANO;
      S_ANO:   n = S_DIS;
      S_DIS:   n = S_REST;
      default: n = S_CAT;
    endcase
    return n;
  endfunction

  function automatic strobe_t stim_strobes(state_t s);
    strobe_t st;
    st = '0;
    case (s)
      S_CAT:   st.cat = 1'b1;
      S_ANO:   st.ano = 1'b1;
      S_DIS:   st.dis = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/stim_sequencer_if.sv
// Run-request and stimulator-output bundle of the stimulation sequencer.
// master = controller side, slave = sequencer side.
interface stim_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int MAG_W  = 5
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            ENABLE;
  logic            RAMP_ST;
  logic            CH_SWEEP_ST;
  logic            EN_ST;
  logic            CAT_ST;
  logic            ANO_ST;
  logic            DIS_ST;
  logic [CH_W-1:0] CH_SEL_ST;
  logic [MAG_W-1:0] MAG_ST;
  logic            PULSE_DONE;
  logic            BLANK_EMG;

  modport master (
    output ENABLE, RAMP_ST, CH_SWEEP_ST,
    input  EN_ST, CAT_ST, ANO_ST, DIS_ST, CH_SEL_ST, MAG_ST, PULSE_DONE, BLANK_EMG
  );

  modport slave (
    input  ENABLE, RAMP_ST, CH_SWEEP_ST,
    output EN_ST, CAT_ST, ANO_ST, DIS_ST, CH_SEL_ST, MAG_ST, PULSE_DONE, BLANK_EMG
  );
endinterface

// File: rtl/stim_phase_timer.sv
// Loadable down-counter; tc is high on the last cycle of a loaded duration
// (load N-1 to get an N-cycle phase).
module stim_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn)          cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/stim_sequencer.sv
// Biphasic stimulation pulse sequencer with magnitude ramp and channel sweep.
// Optional EMG blanking output is built only when STIM_BLANK_EN is defined.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int MAG_W         = 5,
  parameter int CNT_W         = 16,
  parameter int PERIOD_CYC    = 500,
  parameter int CAT_CYC       = 150,
  parameter int IPD_CYC       = 10,
  parameter int ANO_CYC       = 150,
  parameter int DIS_CYC       = 10,
  parameter int MAG_INIT      = 10,
  parameter int MAG_STEP      = 1,
  parameter int MAG_MAX       = 31,
  parameter int PULSES_PER_CH = 5,
  parameter int CH_DEFAULT    = 1,
  parameter int BLANK_CYC     = 20
) (
  input logic            CLK,
  input logic            RESETN,
  stim_sequencer_if.slave bus
);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int ACT_CYC  = CAT_CYC + IPD_CYC + ANO_CYC + DIS_CYC;
  localparam int REST_CYC = PERIOD_CYC - ACT_CYC;

  if (ACT_CYC > PERIOD_CYC) begin : g_chk_period
    $error("stim_sequencer: pulse phases exceed PERIOD_CYC");
  end
  if (ACT_CYC == 0) begin : g_chk_pulse
    $error("stim_sequencer: pulse has no active phase");
  end
  if (MAG_INIT > MAG_MAX) begin : g_chk_mag
    $error("stim_sequencer: MAG_INIT above MAG_MAX");
  end
  if (CH_DEFAULT >= NUM_CH) begin : g_chk_ch
    $error("stim_sequencer: CH_DEFAULT out of range");
  end
  if (NUM_CH < 2 || PULSES_PER_CH < 1 || BLANK_CYC < 0) begin : g_chk_misc
    $error("stim_sequencer: bad NUM_CH, PULSES_PER_CH or BLANK_CYC");
  end

  function automatic logic [CNT_W-1:0] dur(state_t s);
    case (s)
      S_CAT:   return CNT_W'(CAT_CYC);
      S_IPD:   return CNT_W'(IPD_CYC);
      S_ANO:   return CNT_W'(ANO_CYC);
      S_DIS:   return CNT_W'(DIS_CYC);
      S_REST:  return CNT_W'(REST_CYC);
      default: return '0;
    endcase
  endfunction

  // Next phase in the pulse cycle, skipping any phase of zero length.
  function automatic state_t succ(state_t s);
    state_t n;
    state_t r;
    logic   found;
    n     = s;
    r     = S_CAT;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = stim_next_raw(n);
      if (!found && dur(n) != '0) begin
        r     = n;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [MAG_W-1:0] mag_sat_step(logic [MAG_W-1:0] m);
    int sum;
    sum = int'(m) + MAG_STEP;
    return (sum > MAG_MAX) ? MAG_W'(MAG_MAX) : MAG_W'(sum);
  endfunction

  state_t           state, state_nxt;
  logic             stop_req;
  logic             tmr_load, tmr_tc;
  logic [CNT_W-1:0] tmr_val;
  logic             active, is_last, pulse_done;
  logic [MAG_W-1:0] mag;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] pulse_cnt;
  strobe_t          strobes;

  assign active     = (state != S_IDLE) && (state != S_REST);
  assign is_last    = (succ(state) == S_REST) || (succ(state) == S_CAT);
  assign pulse_done = active && tmr_tc && is_last;
  assign tmr_val    = dur(state_nxt) - CNT_W'(1);

  stim_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .resetn   (RESETN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ENABLE) begin
          state_nxt = succ(S_REST);
          tmr_load  = 1'b1;
        end
      end
      S_REST: begin
        if (!bus.ENABLE) begin
          state_nxt = S_IDLE;
        end else if (tmr_tc) begin
          state_nxt = succ(S_REST);
          tmr_load  = 1'b1;
        end
      end
      default: begin
        // A stop request never cuts a pulse short: only the last phase may exit.
        if (tmr_tc) begin
          if (is_last && (stop_req || !bus.ENABLE)) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = succ(state);
            tmr_load  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state    <= S_IDLE;
      stop_req <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_IDLE)        stop_req <= 1'b0;
      else if (active && !bus.ENABLE) stop_req <= 1'b1;
    end
  end

  // Magnitude and channel only move at pulse boundaries; a channel change reloads MAG_INIT.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      mag       <= MAG_W'(MAG_INIT);
      ch        <= CH_W'(CH_DEFAULT);
      pulse_cnt <= '0;
    end else if (pulse_done) begin
      if (bus.CH_SWEEP_ST && pulse_cnt == CNT_W'(PULSES_PER_CH - 1)) begin
        ch        <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
        pulse_cnt <= '0;
        mag       <= MAG_W'(MAG_INIT);
      end else begin
        if (bus.CH_SWEEP_ST) begin
          pulse_cnt <= pulse_cnt + CNT_W'(1);
        end else begin
          ch        <= CH_W'(CH_DEFAULT);
          pulse_cnt <= '0;
        end
        mag <= bus.RAMP_ST ? mag_sat_step(mag) : MAG_W'(MAG_INIT);
      end
    end
  end

  assign strobes        = stim_strobes(state);
  assign bus.EN_ST      = (state != S_IDLE);
  assign bus.CAT_ST     = strobes.cat;
  assign bus.ANO_ST     = strobes.ano;
  assign bus.DIS_ST     = strobes.dis;
  assign bus.PULSE_DONE = pulse_done;
  assign bus.MAG_ST     = mag;
  assign bus.CH_SEL_ST  = ch;

`ifdef STIM_BLANK_EN
  // Tail counter runs only in REST, so leaving REST truncates the blanking window.
  logic [CNT_W-1:0] blank_cnt;

  always_ff @(posedge CLK) begin
    if (!RESETN)                                blank_cnt <= '0;
    else if (pulse_done)                        blank_cnt <= CNT_W'(BLANK_CYC);
    else if (state == S_REST && blank_cnt != '0) blank_cnt <= blank_cnt - CNT_W'(1);
  end

  assign bus.BLANK_EMG = active || (state == S_REST && blank_cnt != '0);
`else
  assign bus.BLANK_EMG = 1'b0;
`endif
endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: per-cycle phase pattern checks plus a
// per-pulse scoreboard of expected channel/magnitude pairs.
module tb_stim_sequencer;
  import stim_pkg::*;

  localparam int NUM_CH = 4, MAG_W = 5, CNT_W = 16;
  localparam int PERIOD = 20, CAT = 4, IPD = 1, ANO = 4, DIS = 2;
  localparam int MAG_INIT = 29, MAG_STEP = 1, MAG_MAX = 31;
  localparam int PPC = 2, CH_DEFAULT = 2, BLANK = 3;
  localparam int BLANK_END = CAT + IPD + ANO + DIS + BLANK;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  stim_sequencer_if #(.NUM_CH(NUM_CH), .MAG_W(MAG_W)) bus ();

  stim_sequencer #(
    .NUM_CH(NUM_CH), .MAG_W(MAG_W), .CNT_W(CNT_W),
    .PERIOD_CYC(PERIOD), .CAT_CYC(CAT), .IPD_CYC(IPD), .ANO_CYC(ANO), .DIS_CYC(DIS),
    .MAG_INIT(MAG_INIT), .MAG_STEP(MAG_STEP), .MAG_MAX(MAG_MAX),
    .PULSES_PER_CH(PPC), .CH_DEFAULT(CH_DEFAULT), .BLANK_CYC(BLANK)
  ) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  int m_mag, m_ch, m_pcnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {EN, CAT, ANO, DIS, PULSE_DONE, BLANK} for cycle c counted from the first CAT cycle = 1.
  function automatic logic [5:0] exp_vec(int c);
    int p;
    logic cat, ano, dis, done, blank;
    p     = ((c - 1) % PERIOD) + 1;
    cat   = (p >= 1) && (p <= CAT);
    ano   = (p >= CAT + IPD + 1) && (p <= CAT + IPD + ANO);
    dis   = (p >= CAT + IPD + ANO + 1) && (p <= CAT + IPD + ANO + DIS);
    done  = (p == CAT + IPD + ANO + DIS);
`ifdef STIM_BLANK_EN
    blank = (p <= BLANK_END);
`else
    blank = 1'b0;
`endif
    return {1'b1, cat, ano, dis, done, blank};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {bus.EN_ST, bus.CAT_ST, bus.ANO_ST, bus.DIS_ST, bus.PULSE_DONE, bus.BLANK_EMG};
  endfunction

  function automatic logic [31:0] obs_chmag();
    return 32'({bus.CH_SEL_ST, bus.MAG_ST});
  endfunction

  function automatic logic [31:0] pack_chmag(int ch, int mag);
    return 32'((ch << MAG_W) | mag);
  endfunction

  // Behavioural effect of one PULSE_DONE with the given ramp/sweep settings.
  task automatic model_step(input bit ramp, input bit sweep);
    bit chg;
    chg = 1'b0;
    if (sweep) begin
      if (m_pcnt == PPC - 1) begin
        m_ch   = (m_ch + 1) % NUM_CH;
        m_pcnt = 0;
        chg    = 1'b1;
      end else begin
        m_pcnt++;
      end
    end else begin
      m_ch   = CH_DEFAULT;
      m_pcnt = 0;
    end
    if (chg)       m_mag = MAG_INIT;
    else if (ramp) m_mag = (m_mag + MAG_STEP > MAG_MAX) ? MAG_MAX : m_mag + MAG_STEP;
    else           m_mag = MAG_INIT;
  endtask

  task automatic wait_pulse_start(output bit ok);
    bit prev;
    prev = bus.CAT_ST;
    ok   = 1'b0;
    for (int n = 0; n < 4 * PERIOD; n++) begin
      tick();
      if (bus.CAT_ST && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = bus.CAT_ST;
    end
  endtask

  // Called during a CAT phase; new settings apply from that pulse's PULSE_DONE.
  task automatic run_pulses(input int n, input bit ramp, input bit sweep);
    bit ok;
    logic [31:0] e;
    bus.RAMP_ST     = ramp;
    bus.CH_SWEEP_ST = sweep;
    for (int i = 0; i < n; i++) begin
      model_step(ramp, sweep);
      sb.push_back(pack_chmag(m_ch, m_mag));
    end
    for (int i = 0; i < n; i++) begin
      wait_pulse_start(ok);
      check("pulse_start_timeout", 32'(ok), 32'd1);
      e = sb.pop_front();
      check("pulse_ch_mag", obs_chmag(), e);
    end
  endtask

  initial begin
    int idle_hits;
    resetn          = 1'b0;
    bus.ENABLE      = 1'b0;
    bus.RAMP_ST     = 1'b0;
    bus.CH_SWEEP_ST = 1'b0;
    m_mag = MAG_INIT; m_ch = CH_DEFAULT; m_pcnt = 0;
    tick();
    tick();
    check("reset_outputs", 32'(obs_vec()), 32'd0);
    check("reset_ch_mag", obs_chmag(), pack_chmag(CH_DEFAULT, MAG_INIT));

    resetn = 1'b1;
    tick();
    check("idle_no_enable", 32'(obs_vec()), 32'd0);

    // Basic pulse shape over one full period and into the next pulse.
    bus.ENABLE = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      check($sformatf("wave_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
    end
    model_step(1'b0, 1'b0);
    check("second_pulse_ch_mag", obs_chmag(), pack_chmag(m_ch, m_mag));

    run_pulses(3, 1'b1, 1'b0);
    run_pulses(10, 1'b1, 1'b1);
    run_pulses(2, 1'b0, 1'b0);
    run_pulses(2, 1'b1, 1'b1);

    // ENABLE dropped during CAT: pulse must finish through DIS, then stay idle.
    tick();
    check("abort_c2", 32'(obs_vec()), 32'(exp_vec(2)));
    bus.ENABLE = 1'b0;
    for (int c = 3; c <= CAT + IPD + ANO + DIS; c++) begin
      tick();
      check($sformatf("abort_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
    end
    model_step(1'b1, 1'b1);
    tick();
    check("abort_idle", 32'(obs_vec()), 32'd0);
    idle_hits = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.EN_ST || bus.CAT_ST) idle_hits++;
    end
    check("abort_no_restart", 32'(idle_hits), 32'd0);

    bus.ENABLE = 1'b1;
    tick();
    check("reentry_c1", 32'(obs_vec()), 32'(exp_vec(1)));
    check("reentry_ch_mag", obs_chmag(), pack_chmag(m_ch, m_mag));

    // Reset mid-ANO.
    for (int c = 2; c <= CAT + IPD + 2; c++) tick();
    check("pre_reset_ano", 32'(obs_vec()), 32'(exp_vec(CAT + IPD + 2)));
    resetn = 1'b0;
    tick();
    check("reset_ano_outputs", 32'(obs_vec()), 32'd0);
    check("reset_ano_ch_mag", obs_chmag(), pack_chmag(CH_DEFAULT, MAG_INIT));
    bus.ENABLE      = 1'b0;
    bus.RAMP_ST     = 1'b0;
    bus.CH_SWEEP_ST = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("post_reset_idle", 32'(obs_vec()), 32'd0);

    // ENABLE dropped in REST: idle on the next cycle.
    bus.ENABLE = 1'b1;
    for (int c = 1; c <= 15; c++) tick();
    check("rest_c15", 32'(obs_vec()), 32'(exp_vec(15)));
    bus.ENABLE = 1'b0;
    tick();
    check("rest_drop_idle", 32'(obs_vec()), 32'd0);
    check("rest_drop_ch_mag", obs_chmag(), pack_chmag(CH_DEFAULT, MAG_INIT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter NUM_CH, default 4: number of stimulation channels (>=2).
REQ-003 Parameter MAG_W, default 5: magnitude code width.
REQ-004 Parameter CNT_W, default 16: width of the phase and period counters.
REQ-005 Parameters PERIOD_CYC=500, CAT_CYC=150, IPD_CYC=10, ANO_CYC=150, DIS_CYC=10: durations in CLK cycles.
REQ-006 Parameters MAG_INIT=10, MAG_STEP=1, MAG_MAX=31: ramp start, increment and ceiling.
REQ-007 Parameters PULSES_PER_CH=5, CH_DEFAULT=1, BLANK_CYC=20: pulses per channel during a sweep, fixed channel, EMG blanking tail.
REQ-008 CLK  in  1  system clock; all logic is rising-edge.
REQ-009 RESETN  in  1  synchronous active-low reset.
REQ-010 ENABLE  in  1  run request.
REQ-011 RAMP_ST  in  1  enable magnitude ramp.
REQ-012 CH_SWEEP_ST  in  1  enable channel sweep.
REQ-013 EN_ST  out  1  stimulator active.
REQ-014 CAT_ST / ANO_ST / DIS_ST  out  1 each  cathodic, anodic and discharge phase strobes.
REQ-015 CH_SEL_ST  out  $clog2(NUM_CH)  active channel.
REQ-016 MAG_ST  out  MAG_W  current magnitude code.
REQ-017 PULSE_DONE  out  1  one-cycle strobe on the last DIS cycle.
REQ-018 BLANK_EMG  out  1  EMG front-end blanking request.

Function
REQ-019 The FSM SHALL have the states IDLE, CAT, IPD, ANO, DIS and REST; each timed state lasts exactly its *_CYC cycles, and REST fills the pulse up to PERIOD_CYC cycles.
REQ-020 IDLE->CAT SHALL occur on the first cycle ENABLE is sampled high, so CAT_ST is high on the next cycle.
REQ-021 The transitions CAT->IPD->ANO->DIS->REST->CAT SHALL be unconditional while ENABLE=1.
REQ-022 A phase with *_CYC=0 SHALL be skipped.
REQ-023 CAT_ST, ANO_ST and DIS_ST SHALL be one-hot or all zero; IPD and REST drive all three low.
REQ-024 EN_ST SHALL be high in every state except IDLE.
REQ-025 ENABLE low in CAT, IPD or ANO SHALL let the pulse complete through DIS before going to IDLE, for charge balance.
REQ-026 ENABLE low in REST or DIS-end SHALL go to IDLE on the next cycle.
REQ-027 The ramp SHALL work as follows:
- RAMP_ST=1: MAG_ST += MAG_STEP at each PULSE_DONE, saturating at MAG_MAX with no wrap.
- RAMP_ST=0: MAG_ST held at MAG_INIT.
- MAG_ST changes only at pulse boundaries, never mid-pulse.
REQ-028 The sweep SHALL work as follows:
- CH_SWEEP_ST=1: after PULSES_PER_CH PULSE_DONEs, CH_SEL_ST increments, wrapping NUM_CH-1 -> 0, and the pulse counter clears.
- CH_SWEEP_ST=0: CH_SEL_ST = CH_DEFAULT and the pulse counter is held at 0.
REQ-029 When a channel change and a ramp step coincide, MAG_ST SHALL load MAG_INIT; the channel change wins.
REQ-030 Toggling RAMP_ST or CH_SWEEP_ST mid-pulse SHALL take effect only at the next PULSE_DONE.
REQ-031 On re-entry from IDLE, MAG_ST and CH_SEL_ST SHALL retain their values; only reset clears them.
REQ-032 It SHALL be an elaboration error if CAT_CYC+IPD_CYC+ANO_CYC+DIS_CYC > PERIOD_CYC, or if MAG_INIT > MAG_MAX, or if CH_DEFAULT >= NUM_CH.

Reset
REQ-033 RESETN=0 at a clock edge SHALL force, on the next cycle, the following outputs regardless of state, including mid-pulse:
- FSM = IDLE
- all strobes, EN_ST, PULSE_DONE and BLANK_EMG = 0
- MAG_ST = MAG_INIT
- CH_SEL_ST = CH_DEFAULT
- counters = 0

Configuration
REQ-034 With STIM_BLANK_EN defined, BLANK_EMG SHALL rise with CAT_ST and stay high through DIS plus BLANK_CYC further cycles, truncated at the period end.
REQ-035 Without STIM_BLANK_EN, BLANK_EMG SHALL be tied to 0, with no blanking counter synthesized.

Structure
REQ-036 Package stim_pkg SHALL hold the state enum typedef and the phase-strobe typedef.
REQ-037 Sub-module stim_phase_timer SHALL provide a loadable down-counter with a terminal-count flag, instantiated once for phase timing.

Verification
REQ-038 With PERIOD=20, CAT=4, IPD=1, ANO=4, DIS=2 and ENABLE high:
- CAT_ST is high for cycles 1-4, low for cycle 5, ANO_ST for 6-9, DIS_ST for 10-11.
- PULSE_DONE fires at cycle 11.
- The next CAT_ST starts at cycle 21.
REQ-039 With RAMP_ST=1, MAG_INIT=29 and MAG_MAX=31: MAG_ST reads 29, 30, 31, 31 across four pulses.
REQ-040 With CH_SWEEP_ST=1, NUM_CH=4 and PULSES_PER_CH=2: CH_SEL_ST reads 0,0,1,1,2,2,3,3,0, and MAG_ST resets to MAG_INIT at each channel change.
REQ-041 ENABLE dropped at CAT cycle 2: ANO and DIS still complete, then EN_ST=0 with no further CAT_ST.
REQ-042 RESETN=0 during ANO: on the next cycle all strobes are 0, EN_ST=0, MAG_ST=MAG_INIT and CH_SEL_ST=CH_DEFAULT.
REQ-043 With STIM_BLANK_EN and BLANK_CYC=3: BLANK_EMG is high for cycles 1-14; without the macro it is constantly 0.
